// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding for the round-robin sequencer
// Purpose : state enum used by the sequencer and any trace helpers.
// Ports   : none (package).
package fsm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Width of a counter that must hold values 0..max_val, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational pointer-based round-robin pick
// Purpose : returns the first set request scanning upward from ptr+1 with wrap,
//           so the channel at ptr (last winner) has the lowest priority.
// Ports   : req    - per-channel request vector
//           ptr    - index of the previous winner
//           winner - index of the chosen channel (0 when nothing found)
//           found  - high when any request is set
module rr_arbiter #(
    parameter int NB_CH = 4,
    parameter int ID_W  = $clog2(NB_CH)
) (
    input  logic [NB_CH-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    int idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        // Offsets 1..NB_CH visit every channel once, ending at ptr itself.
        for (int i = 1; i <= NB_CH; i++) begin
            idx = (int'(ptr) + i) % NB_CH;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fsm_rr_sequencer.sv
// rtl/fsm_rr_sequencer.sv - N-channel round-robin transaction sequencer
// Purpose : grants one requesting channel at a time and accepts its beats via
//           valid/ready until last, MAX_BEATS or watchdog timeout.
// Ports   : aclk, aresetn      - clock, asynchronous active-low reset
//           req/valid/last     - per-channel request, beat valid, final-beat marker
//           grant, grant_id    - one-hot grant (XFER only) and granted index (sticky)
//           ready, busy        - high while in XFER
//           beat_cnt           - beats accepted in current/last transaction
//           timeout            - one-cycle pulse on watchdog abort
module fsm_rr_sequencer
    import fsm_pkg::*;
#(
    parameter int NAME      = 0,
    parameter int NB_CH     = 4,
    parameter int MAX_BEATS = 8,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1),
    parameter int ID_W      = $clog2(NB_CH)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [NB_CH-1:0] req,
    input  logic [NB_CH-1:0] valid,
    input  logic [NB_CH-1:0] last,
    output logic [NB_CH-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             timeout
);

    localparam int WD_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BEATS - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(NB_CH - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;

    logic [ID_W-1:0]   winner;
    logic              found;
    logic              accept;

    rr_arbiter #(
        .NB_CH (NB_CH),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    assign accept = (state_q == XFER) && valid[grant_id_q];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= PTR_RST;
            beat_cnt_q <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        wd_d       = wd_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = XFER;
                    grant_id_d = winner;
                    ptr_d      = winner;
                    beat_cnt_d = '0;
                    wd_d       = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    // An accept always beats the watchdog, even on its threshold cycle.
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    wd_d       = '0;
                    if (last[grant_id_q] || (beat_cnt_q == BEAT_LAST)) begin
                        state_d = IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    if (wd_q == WD_LAST) begin
                        // Abort leaves beat_cnt and ptr untouched.
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NB_CH; i++) begin
            grant[i] = (state_q == XFER) && (grant_id_q == ID_W'(i));
        end
    end

    assign grant_id = grant_id_q;
    assign ready    = (state_q == XFER);
    assign busy     = (state_q == XFER);
    assign beat_cnt = beat_cnt_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_fsm_rr_sequencer.sv
// tb/tb_fsm_rr_sequencer.sv - directed self-checking bench for fsm_rr_sequencer
module tb_fsm_rr_sequencer;

    localparam int NB_CH     = 4;
    localparam int MAX_BEATS = 8;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int ID_W      = $clog2(NB_CH);

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [NB_CH-1:0] req;
    logic [NB_CH-1:0] valid;
    logic [NB_CH-1:0] last;
    logic [NB_CH-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             ready;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    logic [NB_CH-1:0] order [5];

    fsm_rr_sequencer #(
        .NAME      (0),
        .NB_CH     (NB_CH),
        .MAX_BEATS (MAX_BEATS),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W),
        .ID_W      (ID_W)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .req      (req),
        .valid    (valid),
        .last     (last),
        .grant    (grant),
        .grant_id (grant_id),
        .ready    (ready),
        .busy     (busy),
        .beat_cnt (beat_cnt),
        .timeout  (timeout)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [NB_CH-1:0] g, input logic [ID_W-1:0] gid,
                              input logic b, input logic [CNT_W-1:0] bc, input logic to);
        check({tag, ".grant"},    32'(grant),    32'(g));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
        check({tag, ".ready"},    32'(ready),    32'(b));
        check({tag, ".busy"},     32'(busy),     32'(b));
        check({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(bc));
        check({tag, ".timeout"},  32'(timeout),  32'(to));
    endtask

    initial begin
        aresetn = 1'b0;
        req     = '0;
        valid   = '0;
        last    = '0;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        // Reset state
        #10;
        check_outs("rst", 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0);
        #2 aresetn = 1'b1;
        tick();
        tick();
        check_outs("idle_noreq", 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0);

        // req=0110: ch1 wins, three beats with last on the third
        req = 4'b0110;
        tick();
        check_outs("t1_grant", 4'b0010, 2'd1, 1'b1, 4'd0, 1'b0);
        valid = 4'b0010;
        tick();
        check("t1_bc1", 32'(beat_cnt), 32'd1);
        tick();
        check("t1_bc2", 32'(beat_cnt), 32'd2);
        last = 4'b0010;
        tick();
        check_outs("t1_close", 4'b0000, 2'd1, 1'b0, 4'd3, 1'b0);
        req = 4'b0100; valid = '0; last = '0;
        tick();
        check_outs("t1_ch2", 4'b0100, 2'd2, 1'b1, 4'd0, 1'b0);
        valid = 4'b0100; last = 4'b0100;
        tick();
        check("t1_ch2_close", 32'(busy), 32'd0);
        req = '0; valid = '0; last = '0;

        // Fresh reset, then all channels requesting with one-beat transactions
        #1 aresetn = 1'b0;
        #2 aresetn = 1'b1;
        req = 4'b1111; valid = 4'b1111; last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_grant%0d", k), 32'(grant), 32'(order[k]));
            tick();
            check($sformatf("t2_dead%0d", k), 32'(grant), 32'd0);
            check($sformatf("t2_bc%0d", k), 32'(beat_cnt), 32'd1);
        end
        req = '0; valid = '0; last = '0;
        tick();
        check("t2_idle", 32'(busy), 32'd0);

        // ch2 streaming without last: closes on MAX_BEATS; other channels' last ignored
        req = 4'b0100;
        tick();
        check("t3_grant", 32'(grant), 32'b0100);
        valid = 4'b1111; last = 4'b1011;
        for (int k = 1; k <= MAX_BEATS - 1; k++) begin
            tick();
            if (k == 2) req = '0;
        end
        check_outs("t3_bc7", 4'b0100, 2'd2, 1'b1, 4'd7, 1'b0);
        tick();
        check_outs("t3_max", 4'b0000, 2'd2, 1'b0, 4'd8, 1'b0);
        valid = '0; last = '0;
        tick();
        check("t3_idle", 32'(busy), 32'd0);

        // ch0 granted with no valid: watchdog abort 16 cycles after grant
        req = 4'b0001;
        tick();
        check_outs("t4_grant", 4'b0001, 2'd0, 1'b1, 4'd0, 1'b0);
        req = '0;
        for (int k = 1; k < TIMEOUT; k++) tick();
        check_outs("t4_pre", 4'b0001, 2'd0, 1'b1, 4'd0, 1'b0);
        tick();
        check_outs("t4_abort", 4'b0000, 2'd0, 1'b0, 4'd0, 1'b1);
        tick();
        check("t4_pulse_end", 32'(timeout), 32'd0);

        // Accept on the threshold cycle suppresses the abort
        req = 4'b0010;
        tick();
        check("t5_grant", 32'(grant), 32'b0010);
        req = '0;
        for (int k = 1; k < TIMEOUT; k++) tick();
        valid = 4'b0010;
        tick();
        check_outs("t5_saved", 4'b0010, 2'd1, 1'b1, 4'd1, 1'b0);
        valid = '0;
        tick();
        tick();

        // Reset asserted mid-XFER clears outputs immediately
        aresetn = 1'b0;
        #1;
        check_outs("t6_rst", 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0);
        #3 aresetn = 1'b1;
        tick();
        check("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
